// File: rtl/osc_pkg.sv
// osc_pkg: shared defaults, channel type and sweep FSM states for osc_phase_gen
package osc_pkg;
   localparam int NUM_CH_DEF = 4;
   localparam int ACC_W_DEF  = 24;
   localparam int ADDR_W     = 9;
   typedef logic [$clog2(NUM_CH_DEF)-1:0] chan_t;
   typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/osc_phase_gen_if.sv
// osc_phase_gen_if: sample tick, config write channel and phase output stream
interface osc_phase_gen_if import osc_pkg::*; #(
   parameter int NUM_CH = NUM_CH_DEF,
   parameter int ACC_W  = ACC_W_DEF
);
   localparam int CH_W = $clog2(NUM_CH);
   logic              sample_tick;
   logic              cfg_valid;
   logic              cfg_ready;
   logic [CH_W-1:0]   cfg_chan;
   logic [ACC_W-1:0]  cfg_inc;
   logic              cfg_gate;
   logic              cfg_retrig;
   logic              phase_valid;
   logic [CH_W-1:0]   phase_chan;
   logic [ADDR_W-1:0] phase_addr;
   logic              phase_active;
   logic              phase_last;
   logic              overrun;
   modport master (
      output sample_tick, cfg_valid, cfg_chan, cfg_inc, cfg_gate, cfg_retrig,
      input  cfg_ready, phase_valid, phase_chan, phase_addr, phase_active, phase_last, overrun
   );
   modport slave (
      input  sample_tick, cfg_valid, cfg_chan, cfg_inc, cfg_gate, cfg_retrig,
      output cfg_ready, phase_valid, phase_chan, phase_addr, phase_active, phase_last, overrun
   );
endinterface

// File: rtl/osc_phase_gen.sv
// osc_phase_gen: time-multiplexed phase accumulators swept once per sample tick
module osc_phase_gen import osc_pkg::*; #(
   parameter int NUM_CH = NUM_CH_DEF,
   parameter int ACC_W  = ACC_W_DEF
) (
   input  logic           clk,
   input  logic           reset,
   osc_phase_gen_if.slave bus
);
   localparam int CH_W = $clog2(NUM_CH);
   localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
   state_t            state_q, state_d;
   logic [CH_W-1:0]   chan_q, chan_d;
   logic              pend_q, pend_d;
   logic              ovr_q, ovr_d;
   logic              rdy_q, rdy_d;
   logic [ACC_W-1:0]  acc_q [NUM_CH];
   logic [ACC_W-1:0]  acc_d [NUM_CH];
   logic [ACC_W-1:0]  inc_q [NUM_CH];
   logic [ACC_W-1:0]  inc_d [NUM_CH];
   logic [NUM_CH-1:0] gate_q, gate_d;
   logic              run, last, accept;
   assign run    = state_q == RUN;
   assign last   = chan_q == LAST_CH;
   assign accept = bus.cfg_valid & rdy_q;
   always_comb begin
      state_d = state_q;
      chan_d  = chan_q;
      acc_d   = acc_q;
      inc_d   = inc_q;
      gate_d  = gate_q;
      pend_d  = pend_q | (run & bus.sample_tick);
      ovr_d   = ovr_q | (run & bus.sample_tick);
      if (run) begin
         acc_d[chan_q] = gate_q[chan_q] ? acc_q[chan_q] + inc_q[chan_q] : acc_q[chan_q];
         chan_d        = chan_q + 1'b1;
         if (last) begin
            state_d = pend_d ? RUN : IDLE;
            pend_d  = 1'b0;
         end
      end else begin
         if (accept) begin
            inc_d[bus.cfg_chan]  = bus.cfg_inc;
            gate_d[bus.cfg_chan] = bus.cfg_gate;
            acc_d[bus.cfg_chan]  = bus.cfg_retrig ? '0 : acc_q[bus.cfg_chan];
         end
         if (bus.sample_tick | pend_q) begin
            state_d = RUN;
            chan_d  = '0;
            pend_d  = 1'b0;
         end
      end
      rdy_d = state_d == IDLE;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         chan_q  <= '0;
         pend_q  <= 1'b0;
         ovr_q   <= 1'b0;
         rdy_q   <= 1'b0;
         acc_q   <= '{default: '0};
         inc_q   <= '{default: '0};
         gate_q  <= '0;
      end else begin
         state_q <= state_d;
         chan_q  <= chan_d;
         pend_q  <= pend_d;
         ovr_q   <= ovr_d;
         rdy_q   <= rdy_d;
         acc_q   <= acc_d;
         inc_q   <= inc_d;
         gate_q  <= gate_d;
      end
   end
   assign bus.cfg_ready    = rdy_q;
   assign bus.phase_valid  = run;
   assign bus.phase_chan   = chan_q;
   assign bus.phase_addr   = run ? acc_q[chan_q][ACC_W-1 -: ADDR_W] : '0;
   assign bus.phase_active = run & gate_q[chan_q];
   assign bus.phase_last   = run & last;
   assign bus.overrun      = ovr_q;
endmodule
